cdb_writeback: RTL and testbench

Common-data-bus arbiter and writeback stage, directly upstream of the register rename-status/register-file table. Up to NUM_UNITS functional units post completed results (producer tag, destination register, value). Each cycle the block round-robin grants one result and broadcasts it on the CDB. One cycle later it retires the value into the register file only if the rename table still names that producer for the destination.

---
 rtl/cdb_writeback.sv | 93 +++++++++
 tb/tb_cdb_writeback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback.sv
// Common-data-bus arbiter and writeback stage: round-robin grants one result per
// cycle, broadcasts it next cycle, and retires it if the rename tag still matches.
module cdb_writeback #(
    parameter int NUM_UNITS = 4,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32,
    parameter logic [UNIT_SIZE-1:0] READY_TAG = 8'b01111111
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_UNITS-1:0]           req,
    input  logic [NUM_UNITS*UNIT_SIZE-1:0] req_tag,
    input  logic [NUM_UNITS*6-1:0]         req_reg,
    input  logic [NUM_UNITS*WORD_SIZE-1:0] req_val,
    output logic [NUM_UNITS-1:0]           grant,
    input  logic                           stall,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_val,
    output logic [5:0]                     rrs_r,
    input  logic [UNIT_SIZE-1:0]           rrs_tag,
    output logic                           rrs_writable,
    output logic [UNIT_SIZE-1:0]           rrs_write,
    output logic [WORD_SIZE-1:0]           rrs_inrf,
    output logic [15:0]                    bcast_count
);

    localparam int PW = $clog2(NUM_UNITS);
    localparam logic [PW-1:0] LAST = PW'(NUM_UNITS - 1);

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win;
    logic                 found;
    logic [UNIT_SIZE-1:0] win_tag;
    logic [5:0]           win_reg;
    logic [WORD_SIZE-1:0] win_val;

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        grant   = '0;
        win     = '0;
        found   = 1'b0;
        win_tag = '0;
        win_reg = '0;
        win_val = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_UNITS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
                win_tag    = req_tag[idx*UNIT_SIZE +: UNIT_SIZE];
                win_reg    = req_reg[idx*6 +: 6];
                win_val    = req_val[idx*WORD_SIZE +: WORD_SIZE];
            end
        end
        if (rst || stall) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_tag     <= READY_TAG;
            cdb_val     <= '0;
            rrs_r       <= '0;
            ptr         <= '0;
            bcast_count <= '0;
        end else begin
            cdb_valid <= |grant;
            if (|grant) begin
                cdb_tag     <= win_tag;
                cdb_val     <= win_val;
                rrs_r       <= win_reg;
                ptr         <= (win == LAST) ? '0 : win + 1'b1;
                bcast_count <= bcast_count + 16'd1;
            end
        end
    end

    // A younger rename of the destination, or a ready/garbage tag, blocks retirement.
    always_comb begin
        rrs_writable = cdb_valid & ~flush & ~rst
                     & (rrs_tag == cdb_tag)
                     & (cdb_tag != READY_TAG);
        rrs_write    = READY_TAG;
        rrs_inrf     = cdb_val;
    end

endmodule

// File: tb/tb_cdb_writeback.sv
// Scoreboard bench for cdb_writeback: expected broadcasts queued at grant time,
// popped and compared when the CDB shows them.
module tb_cdb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_tag;
    logic [23:0] req_reg;
    logic [127:0] req_val;
    logic [3:0]  grant;
    logic        stall;
    logic        flush;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [5:0]  rrs_r;
    logic [7:0]  rrs_tag;
    logic        rrs_writable;
    logic [7:0]  rrs_write;
    logic [31:0] rrs_inrf;
    logic [15:0] bcast_count;

    cdb_writeback dut (
        .clk(clk), .rst(rst), .req(req), .req_tag(req_tag),
        .req_reg(req_reg), .req_val(req_val), .grant(grant),
        .stall(stall), .flush(flush), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_val(cdb_val), .rrs_r(rrs_r),
        .rrs_tag(rrs_tag), .rrs_writable(rrs_writable),
        .rrs_write(rrs_write), .rrs_inrf(rrs_inrf),
        .bcast_count(bcast_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tag;
        logic [5:0]  r;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  rt[64];
    logic        u_req[4];
    logic        u_cont[4];
    logic [7:0]  u_tag[4];
    logic [5:0]  u_reg[4];
    logic [31:0] u_val[4];
    logic        exp_valid;
    int          total = 0;
    int          bad = 0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i]               = u_req[i];
            req_tag[i*8 +: 8]    = u_tag[i];
            req_reg[i*6 +: 6]    = u_reg[i];
            req_val[i*32 +: 32]  = u_val[i];
        end
    end

    assign rrs_tag = rt[rrs_r];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setu(input int i, input logic [7:0] t, input logic [5:0] r,
                        input logic [31:0] v, input logic cont);
        u_req[i]  = 1'b1;
        u_tag[i]  = t;
        u_reg[i]  = r;
        u_val[i]  = v;
        u_cont[i] = cont;
    endtask

    task automatic cycle(input logic [3:0] g);
        ent_t e;
        logic wb;
        @(negedge clk);
        check("cdb_valid", cdb_valid, exp_valid);
        if (cdb_valid) begin
            if (q.size() == 0) begin
                check("sb_size", 64'(q.size()), 1);
            end else begin
                e  = q.pop_front();
                wb = (rt[e.r] == e.tag) && (e.tag != 8'h7F) && !flush && !rst;
                check("cdb_tag", cdb_tag, e.tag);
                check("cdb_val", cdb_val, e.v);
                check("rrs_r", rrs_r, e.r);
                check("rrs_writable", rrs_writable, wb);
                if (wb) begin
                    check("rrs_write", rrs_write, 8'h7F);
                    check("rrs_inrf", rrs_inrf, e.v);
                end
            end
        end else begin
            check("rrs_writable_idle", rrs_writable, 1'b0);
        end
        check("grant", grant, g);
        for (int i = 0; i < 4; i++)
            if (g[i]) q.push_back('{u_tag[i], u_reg[i], u_val[i]});
        @(posedge clk);
        exp_valid = (g != 4'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                if (u_cont[i]) u_val[i] = u_val[i] + 32'd100;
                else u_req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(4'b0000);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rt[i] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            u_req[i] = 0; u_cont[i] = 0; u_tag[i] = 0; u_reg[i] = 0; u_val[i] = 0;
        end
        rst = 1'b1; stall = 1'b0; flush = 1'b0; exp_valid = 1'b0;
        @(posedge clk);
        #1;
        u_req[0] = 1'b1; u_req[3] = 1'b1;
        do_reset();
        u_req[0] = 1'b0; u_req[3] = 1'b0;
        check("rst_tag", cdb_tag, 8'h7F);
        check("rst_val", cdb_val, 0);
        check("rst_rrs_r", rrs_r, 0);
        check("rst_count", bcast_count, 0);

        // single result, matching rename tag
        rt[5] = 8'd3;
        setu(0, 8'd3, 6'd5, -32'sd7, 1'b0);
        cycle(4'b0001);
        cycle(4'b0000);
        check("count_1", bcast_count, 1);

        // all units continuous from p=0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rt[20+i] = 8'(10 + i);
            setu(i, 8'(10 + i), 6'(20 + i), 32'(1000 * (i + 1)), 1'b1);
        end
        cycle(4'b0001);
        cycle(4'b0010);
        cycle(4'b0100);
        cycle(4'b1000);
        cycle(4'b0001);
        for (int i = 0; i < 4; i++) u_req[i] = 1'b0;
        cycle(4'b0000);
        check("count_5", bcast_count, 5);

        // renamed destination: broadcast without writeback
        rt[9] = 8'd4;
        setu(2, 8'd6, 6'd9, 32'h1234, 1'b0);
        cycle(4'b0100);
        cycle(4'b0000);

        // stall then rotation from p=0
        do_reset();
        setu(1, 8'd21, 6'd30, 32'd111, 1'b0);
        setu(3, 8'd23, 6'd31, 32'd333, 1'b0);
        rt[30] = 8'd21; rt[31] = 8'd23;
        stall = 1'b1;
        cycle(4'b0000);
        cycle(4'b0000);
        cycle(4'b0000);
        stall = 1'b0;
        cycle(4'b0010);
        cycle(4'b1000);
        cycle(4'b0000);

        // flush kills one writeback while arbitration continues
        rt[7] = 8'd2; rt[11] = 8'd8;
        setu(1, 8'd2, 6'd7, 32'hCAFE, 1'b0);
        cycle(4'b0010);
        setu(0, 8'd8, 6'd11, 32'hBEEF, 1'b0);
        flush = 1'b1;
        cycle(4'b0001);
        flush = 1'b0;
        cycle(4'b0000);

        // reset in the middle of a stream
        for (int i = 0; i < 4; i++)
            setu(i, 8'(10 + i), 6'(20 + i), 32'(50 + i), 1'b1);
        cycle(4'b0010);
        do_reset();
        check("midrst_count", bcast_count, 0);
        check("midrst_valid", cdb_valid, 0);
        cycle(4'b0001);
        for (int i = 0; i < 4; i++) u_req[i] = 1'b0;
        cycle(4'b0000);
        check("final_count", bcast_count, 1);
        check("sb_drained", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
